// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding, transaction lengths and bus levels
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK_A,
    ST_REG,
    ST_ACK_R,
    ST_DATA,
    ST_ACK_D,
    ST_RSTART,
    ST_ADDR_R,
    ST_ACK_AR,
    ST_READ,
    ST_MNACK,
    ST_STOP,
    ST_DONE
  } state_t;

  localparam int QUARTERS_WR = 116;
  localparam int QUARTERS_RD = 156;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

  function automatic logic is_ack_state(input state_t s);
    return (s == ST_ACK_A) || (s == ST_ACK_R) || (s == ST_ACK_D) || (s == ST_ACK_AR);
  endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// rtl/i2c_bit_timer.sv - quarter-bit counter with phase index and SCL stretch freeze
module i2c_bit_timer #(
  parameter int CLK_DIV = 63
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  input  logic       i_scl,
  output logic [1:0] o_phase,
  output logic       o_qend
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_phase;
  logic          w_freeze;

  // A slave holding SCL low during Q2 stalls the bit, cycle for cycle.
  assign w_freeze = (r_phase == 2'd2) && !i_scl;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      r_cnt   <= '0;
      r_phase <= '0;
    end else if (!w_freeze) begin
      if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_phase <= r_phase + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_phase = r_phase;
  assign o_qend  = i_run && !w_freeze && (r_cnt == LAST);

endmodule

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - register-style I2C master: one-byte write or one-byte read with NACK reporting
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 63
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic [6:0] i_dev_addr,
  input  logic [7:0] i_reg_addr,
  input  logic [7:0] i_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack_err,
  output logic [7:0] o_rdata,
  output logic       o_scl_o,
  output logic       o_sda_o,
  output logic       o_scl_oe,
  output logic       o_sda_oe,
  input  logic       i_scl_i,
  input  logic       i_sda_i
);

  state_t      r_state, w_next;
  logic        r_rw;
  logic [6:0]  r_dev;
  logic [7:0]  r_reg, r_wdata, r_shift, r_rdata;
  logic [2:0]  r_bit;
  logic        r_ack_err;
  logic        w_run, w_qend, w_sample, w_bit_end, w_last_bit, w_byte_state;
  logic        w_scl_oe, w_sda_oe;
  logic [1:0]  w_phase;

  assign w_run = (r_state != ST_IDLE) && (r_state != ST_DONE);

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_run   (w_run),
    .i_scl   (i_scl_i),
    .o_phase (w_phase),
    .o_qend  (w_qend)
  );

  assign w_sample     = w_qend && (w_phase == 2'd2);
  assign w_bit_end    = w_qend && (w_phase == 2'd3);
  assign w_last_bit   = (r_bit == 3'd7);
  assign w_byte_state = (r_state == ST_ADDR) || (r_state == ST_REG) || (r_state == ST_DATA) ||
                        (r_state == ST_ADDR_R) || (r_state == ST_READ);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_next = ST_START;
      ST_START:  if (w_bit_end) w_next = ST_ADDR;
      ST_ADDR:   if (w_bit_end && w_last_bit) w_next = ST_ACK_A;
      ST_ACK_A:  if (w_bit_end) w_next = r_ack_err ? ST_STOP : ST_REG;
      ST_REG:    if (w_bit_end && w_last_bit) w_next = ST_ACK_R;
      ST_ACK_R:  if (w_bit_end) w_next = r_ack_err ? ST_STOP : (r_rw ? ST_RSTART : ST_DATA);
      ST_DATA:   if (w_bit_end && w_last_bit) w_next = ST_ACK_D;
      ST_ACK_D:  if (w_bit_end) w_next = ST_STOP;
      ST_RSTART: if (w_bit_end) w_next = ST_ADDR_R;
      ST_ADDR_R: if (w_bit_end && w_last_bit) w_next = ST_ACK_AR;
      ST_ACK_AR: if (w_bit_end) w_next = r_ack_err ? ST_STOP : ST_READ;
      ST_READ:   if (w_bit_end && w_last_bit) w_next = ST_MNACK;
      ST_MNACK:  if (w_bit_end) w_next = ST_STOP;
      ST_STOP:   if (w_bit_end) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rw      <= 1'b0;
      r_dev     <= '0;
      r_reg     <= '0;
      r_wdata   <= '0;
      r_shift   <= '0;
      r_bit     <= '0;
      r_ack_err <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (r_state == ST_IDLE && i_start) begin
        r_rw      <= i_rw;
        r_dev     <= i_dev_addr;
        r_reg     <= i_reg_addr;
        r_wdata   <= i_wdata;
        r_bit     <= '0;
        r_ack_err <= 1'b0;
      end
      if (w_sample && is_ack_state(r_state) && (i_sda_i != ACK_LVL)) r_ack_err <= 1'b1;
      if (w_sample && r_state == ST_READ) r_shift <= {r_shift[6:0], i_sda_i};
      if (w_bit_end) begin
        case (r_state)
          ST_START:  r_shift <= {r_dev, 1'b0};
          ST_ACK_A:  r_shift <= r_reg;
          ST_ACK_R:  r_shift <= r_wdata;
          ST_RSTART: r_shift <= {r_dev, 1'b1};
          ST_ADDR, ST_REG, ST_DATA, ST_ADDR_R: r_shift <= {r_shift[6:0], 1'b0};
          ST_MNACK:  r_rdata <= r_shift;
          default:   ;
        endcase
        // Wraps back to zero after the eighth bit, ready for the next byte.
        if (w_byte_state) r_bit <= r_bit + 3'd1;
      end
    end
  end

  always_comb begin
    w_scl_oe = 1'b0;
    w_sda_oe = 1'b0;
    case (r_state)
      ST_START: begin
        w_sda_oe = w_phase[1];
        w_scl_oe = (w_phase == 2'd3);
      end
      ST_RSTART: begin
        w_sda_oe = w_phase[1];
        w_scl_oe = (w_phase == 2'd0) || (w_phase == 2'd3);
      end
      ST_STOP: begin
        w_sda_oe = !w_phase[1];
        w_scl_oe = (w_phase == 2'd0);
      end
      ST_ADDR, ST_REG, ST_DATA, ST_ADDR_R: begin
        w_sda_oe = !r_shift[7];
        w_scl_oe = !w_phase[1];
      end
      ST_ACK_A, ST_ACK_R, ST_ACK_D, ST_ACK_AR, ST_READ, ST_MNACK: begin
        w_scl_oe = !w_phase[1];
      end
      default: ;
    endcase
  end

  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = (r_state == ST_DONE);
  assign o_ack_err = r_ack_err;
  assign o_rdata   = r_rdata;
  assign o_scl_o   = 1'b0;
  assign o_sda_o   = 1'b0;
  assign o_scl_oe  = w_scl_oe;
  assign o_sda_oe  = w_sda_oe;

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - i2c_master bench with a bus-level slave model and transaction reference model
module tb_i2c_master;

  localparam int         CD      = 4;
  localparam logic [6:0] SLV     = 7'h70;
  localparam int         STRETCH = 20;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_rw = 1'b0;
  logic [6:0] i_dev = '0;
  logic [7:0] i_reg = '0;
  logic [7:0] i_wd = '0;
  logic       stretch = 1'b0;
  logic       o_busy, o_done, o_ack_err, o_scl_o, o_sda_o, o_scl_oe, o_sda_oe;
  logic [7:0] o_rdata;
  logic       scl_line, sda_line;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Slave / bus monitor state, written only by the monitor process.
  logic       sl_low = 1'b0;
  int         sl_bits = 0;
  logic [7:0] sl_byte = '0;
  logic [7:0] sl_txb = '0;
  logic       sl_addr = 1'b0, sl_sel = 1'b0, sl_go_tx = 1'b0, sl_tx = 1'b0, sl_mack = 1'b0;
  logic       scl_prev = 1'b1, sda_prev = 1'b1, scl_now, sda_now;
  int         n_starts = 0, n_stops = 0;
  logic [7:0] mon_q[$];
  logic [7:0] slave_rdata = '0;

  logic [7:0] model_rdata = '0;
  logic       r_rw_rand;
  logic [6:0] r_dev_rand;
  int         t0_rst;

  assign scl_line = !(o_scl_oe || stretch);
  assign sda_line = !(o_sda_oe || sl_low);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_master #(.CLK_DIV(CD)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_rw       (i_rw),
    .i_dev_addr (i_dev),
    .i_reg_addr (i_reg),
    .i_wdata    (i_wd),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_ack_err  (o_ack_err),
    .o_rdata    (o_rdata),
    .o_scl_o    (o_scl_o),
    .o_sda_o    (o_sda_o),
    .o_scl_oe   (o_scl_oe),
    .o_sda_oe   (o_sda_oe),
    .i_scl_i    (scl_line),
    .i_sda_i    (sda_line)
  );

  // Slave at address SLV: logs master-written bytes, ACKs when selected, returns slave_rdata on reads.
  always @(negedge clk) begin
    scl_now = scl_line;
    sda_now = sda_line;
    if (scl_prev && scl_now && sda_prev && !sda_now) begin
      n_starts = n_starts + 1;
      sl_bits = 0; sl_addr = 1'b1; sl_tx = 1'b0; sl_low = 1'b0;
    end else if (scl_prev && scl_now && !sda_prev && sda_now) begin
      n_stops = n_stops + 1;
      sl_bits = 0; sl_tx = 1'b0; sl_low = 1'b0; sl_sel = 1'b0;
    end else if (!scl_prev && scl_now) begin
      if (sl_bits < 8) sl_byte = {sl_byte[6:0], sda_now};
      else if (sl_tx) sl_mack = sda_now;
      sl_bits = sl_bits + 1;
    end else if (scl_prev && !scl_now) begin
      if (sl_bits == 8) begin
        if (sl_tx) sl_low = 1'b0;
        else begin
          mon_q.push_back(sl_byte);
          if (sl_addr) begin
            sl_sel   = (sl_byte[7:1] == SLV);
            sl_go_tx = sl_sel && sl_byte[0];
            sl_addr  = 1'b0;
          end else sl_go_tx = 1'b0;
          sl_low = sl_sel;
        end
      end else if (sl_bits == 9) begin
        sl_bits = 0;
        if (sl_tx) begin
          sl_tx = 1'b0; sl_low = 1'b0;
        end else if (sl_go_tx) begin
          sl_tx = 1'b1; sl_txb = slave_rdata;
          sl_low = !sl_txb[7]; sl_txb = {sl_txb[6:0], 1'b0};
        end else sl_low = 1'b0;
      end else if (sl_tx && sl_bits > 0) begin
        sl_low = !sl_txb[7]; sl_txb = {sl_txb[6:0], 1'b0};
      end
    end
    scl_prev = scl_now;
    sda_prev = sda_now;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Caller is positioned #1 after a posedge; the start is presented in that cycle (T0).
  task automatic run_txn(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [7:0] rd,
                         input int stretch_at, input int ign_at);
    int         t0, q, got, base_b, base_s, base_p;
    logic       sel;
    logic [7:0] exp_b[$];
    slave_rdata = rd;
    base_b = mon_q.size(); base_s = n_starts; base_p = n_stops;
    i_rw = rw; i_dev = dev; i_reg = rg; i_wd = wd; i_start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    i_start = 1'b0; i_rw = ~rw; i_dev = ~dev; i_reg = ~rg; i_wd = ~wd;
    check("busy_after_accept", o_busy, 1);

    sel = (dev == SLV);
    exp_b.push_back({dev, 1'b0});
    if (!sel) q = 4 + 9*4 + 4;
    else if (!rw) begin
      q = 4 + 3*(9*4) + 4;
      exp_b.push_back(rg); exp_b.push_back(wd);
    end else begin
      q = 4 + 2*(9*4) + 4 + 9*4 + 9*4 + 4;
      exp_b.push_back(rg); exp_b.push_back({dev, 1'b1});
    end

    got = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (stretch_at >= 0 && cyc == t0 + stretch_at) stretch = 1'b1;
      if (stretch_at >= 0 && cyc == t0 + stretch_at + STRETCH) stretch = 1'b0;
      if (ign_at >= 0 && cyc == t0 + ign_at) i_start = 1'b1;
      if (ign_at >= 0 && cyc == t0 + ign_at + 1) i_start = 1'b0;
      if (o_done) begin got = cyc; break; end
    end
    stretch = 1'b0;

    check("done_cycle", got - t0, 1 + q*CD + ((stretch_at >= 0) ? STRETCH : 0));
    check("ack_err", o_ack_err, !sel);
    if (sel && rw) model_rdata = rd;
    check("rdata", o_rdata, model_rdata);
    check("byte_count", mon_q.size() - base_b, exp_b.size());
    foreach (exp_b[i])
      if (base_b + i < mon_q.size()) check($sformatf("byte%0d", i), mon_q[base_b + i], exp_b[i]);
    check("start_count", n_starts - base_s, (sel && rw) ? 2 : 1);
    check("stop_count", n_stops - base_p, 1);
    if (sel && rw) check("master_nack", sl_mack, 1);

    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("busy_after_done", o_busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_ack_err", o_ack_err, 0);
    check("rst_rdata", o_rdata, 8'h00);
    check("rst_scl_oe", o_scl_oe, 0);
    check("rst_sda_oe", o_sda_oe, 0);
    check("rst_scl_o", o_scl_o, 0);
    check("rst_sda_o", o_sda_o, 0);
    i_rst = 1'b0;
    @(posedge clk); #1;

    run_txn(1'b0, SLV, 8'h12, 8'hA5, 8'h00, -1, -1);
    run_txn(1'b1, SLV, 8'h34, 8'h00, 8'h5C, -1, 50);
    run_txn(1'b0, 7'h22, 8'h12, 8'hA5, 8'h00, -1, -1);
    run_txn(1'b1, 7'h15, 8'h40, 8'h00, 8'h99, -1, -1);
    // Stretch starts with Q2 of reg-byte bit 3 (fifth bit sent).
    run_txn(1'b0, SLV, 8'h12, 8'hA5, 8'h00, 1 + (4 + 36 + 4*4 + 2)*CD, -1);
    run_txn(1'b1, SLV, 8'h80, 8'h00, 8'h01, 1 + (4 + 36 + 36 + 4 + 36 + 7*4 + 2)*CD, -1);

    for (int k = 0; k < 8; k++) begin
      r_rw_rand  = 1'($urandom_range(0, 1));
      r_dev_rand = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV;
      run_txn(r_rw_rand, r_dev_rand, 8'($urandom), 8'($urandom), 8'($urandom), -1, -1);
    end

    i_rw = 1'b0; i_dev = SLV; i_reg = 8'hC3; i_wd = 8'h3C; i_start = 1'b1;
    t0_rst = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (50*CD - 1) @(posedge clk);
    #1;
    check("busy_mid_reg", o_busy, 1);
    check("mid_reg_cycle", cyc - t0_rst, 50*CD);
    i_rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_scl_oe", o_scl_oe, 0);
    check("midrst_sda_oe", o_sda_oe, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    check("midrst_rdata", o_rdata, 8'h00);
    i_rst = 1'b0;
    model_rdata = 8'h00;
    @(posedge clk); #1;
    run_txn(1'b1, SLV, 8'h77, 8'h00, 8'hE6, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-controller I2C master for register-style transactions: one-byte write (START, addr+W, reg, data, STOP) or one-byte read (START, addr+W, reg, repeated START, addr+R, data, NACK, STOP). It is the initiator counterpart to `i2c_slave` and drives the same open-drain pad triplets on the `uio` bus. It supports slave clock stretching and reports NACKs.

## Interface
- `CLK_DIV`, default 63: clk cycles per quarter bit-period; 25 MHz/(4·63) ≈ 99 kHz. Legal range is ≥2.
- `clk  in  1`: single clock, all logic on posedge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: one-cycle request. Sampled only when `busy`=0, otherwise ignored.
- `rw  in  1`: 0 = write, 1 = read. Latched with `start`.
- `dev_addr  in  7`: 7-bit slave address. Latched with `start`.
- `reg_addr  in  8`: register byte. Latched with `start`.
- `wdata  in  8`: write data. Latched with `start`.
- `busy  out  1`: high from the cycle after start-accept through the `done` cycle.
- `done  out  1`: one-cycle pulse at transaction end.
- `ack_err  out  1`: valid with `done`. 1 if any slave ACK slot read high. Held until the next accept.
- `rdata  out  8`: read byte. Updated only on a successful read. Held otherwise.
- `scl_o, sda_o  out  1`: constant 0 (open-drain).
- `scl_oe, sda_oe  out  1`: 1 = pull line low.
- `scl_i, sda_i  in  1`: pad inputs, already synchronised externally.

## Operation
- **Quarter tick.** The quarter counter runs 0..CLK_DIV-1 only while `busy`. A quarter ends when it wraps. Each bit has phases Q0..Q3.
- **Data bit.**
  - Q0–Q1: SCL low. SDA is updated at the start of Q0.
  - Q2–Q3: SCL released.
  - `sda_i` is sampled on the last cycle of Q2.
- **Clock stretching.** In Q2, the counter is frozen while `scl_i`=0.
- **States:** IDLE → START → ADDR → ACK → REG → ACK → (write: DATA → ACK → STOP) | (read: RSTART → ADDR_R → ACK → READ → MNACK → STOP) → DONE → IDLE.
- **START.**
  - Q0–Q1: SDA and SCL released.
  - Q2: SDA low.
  - Q3: SCL low.
- **RSTART.**
  - Q0: SDA released, SCL low.
  - Q1: SCL released.
  - Q2: SDA low.
  - Q3: SCL low.
- **STOP.**
  - Q0–Q1: SDA low, SCL low then released at Q1.
  - Q2–Q3: SDA released.
- **Bytes.** Shifted MSB first. The address byte is {dev_addr, 0} in ADDR and {dev_addr, 1} in ADDR_R.
- **ACK slot.** Master releases SDA. A sampled 1 sets `ack_err` and jumps directly to STOP at the next bit boundary, skipping remaining bytes.
- **READ.** Master releases SDA and shifts in 8 sampled bits.
- **MNACK.** Master releases SDA (NACK). `rdata` is loaded from the shift register at the end of MNACK.
- **Reset mid-transaction.** All outputs return to reset values on the next edge. The bus is released with no STOP generated.

## Timing
- **Reset values:** `busy`=0, `done`=0, `ack_err`=0, `rdata`=0x00, `scl_oe`=0, `sda_oe`=0.
- **Start accept.**
  - Accept cycle is T0.
  - `busy`=1 and START Q0 begin at T0+1.
- **Transaction length.**
  - Write: 116 quarters.
  - Read: 156 quarters.
  - `done` is asserted for exactly one cycle in the first cycle after the final STOP quarter: T0+1+116·CLK_DIV (write) or T0+1+156·CLK_DIV (read), assuming no stretching.
  - `busy` falls the cycle after `done`.
- **After a NACK:** total length = quarters up to and including the failing ACK bit + 4 (STOP).
- **Back-to-back requests.** A `start` on the cycle after `busy` falls is accepted. A `start` during `busy` or during `done` is dropped.
- **Bit-time extension.** Stretching extends only Q2 of the affected bit, cycle for cycle.

## Structure
- `i2c_pkg` holds:
  - the state enum;
  - `QUARTERS_WR`=116 and `QUARTERS_RD`=156;
  - ACK/NACK level constants.

  These are shared with `i2c_slave` tests.
- One natural sub-module, `i2c_bit_timer`: quarter counter, phase index, stretch freeze, quarter-end strobe.
- Byte sequencing and shifting stay in `i2c_master`.

## Test plan
- **Write.** CLK_DIV=4, `start` with rw=0, dev 0x70, reg 0x12, wdata 0xA5, slave model ACKs.
  - SDA bytes observed on SCL rises are 0xE0, 0x12, 0xA5.
  - `done` at T0+465, `ack_err`=0.
- **Read.** dev 0x70, reg 0x34, slave returns 0x5C.
  - Bytes are 0xE0, 0x34, repeated START, 0xE1, then the master NACKs.
  - `rdata`=0x5C and `done` at T0+625.
- **Address NACK.** No slave present.
  - `ack_err`=1 after the first ACK slot.
  - STOP follows, `done` at T0+1+(4+36+4)·4=T0+177.
  - `rdata` is unchanged.
- **Clock stretch.** Slave holds SCL low for 20 cycles in Q2 of the reg byte bit 3.
  - `done` is delayed by exactly 20 cycles.
  - Data is unchanged.
- **Reset and ignored start.**
  - `rst` asserted mid-REG byte: next cycle `scl_oe`=`sda_oe`=0 and `busy`=0.
  - A second `start` pulsed while busy produces no extra transaction.
